// File: rtl/simd_result_merger.sv
// simd_result_merger: per-slice FIFOs merged into one full-width VRF write once every slice has a head entry
module simd_result_merger #(
    parameter int NrSIMD     = 2,
    parameter int ElenW      = 64,
    parameter int VAddrWidth = 8,
    parameter int VidWidth   = 3,
    parameter int Depth      = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [NrSIMD-1:0]             slice_req_i,
    input  logic [NrSIMD*VidWidth-1:0]    slice_id_i,
    input  logic [NrSIMD*VAddrWidth-1:0]  slice_addr_i,
    input  logic [NrSIMD*ElenW-1:0]       slice_wdata_i,
    input  logic [NrSIMD*ElenW/8-1:0]     slice_be_i,
    output logic [NrSIMD-1:0]             slice_gnt_o,
    output logic                          result_req_o,
    output logic [VidWidth-1:0]           result_id_o,
    output logic [VAddrWidth-1:0]         result_addr_o,
    output logic [NrSIMD*ElenW-1:0]       result_wdata_o,
    output logic [NrSIMD*ElenW/8-1:0]     result_be_o,
    input  logic                          result_gnt_i,
    output logic                          mismatch_o,
    output logic                          busy_o
);
    localparam int BW = ElenW / 8;
    localparam int IA = VidWidth + VAddrWidth;
    localparam int EW = IA + ElenW + BW;
    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    logic [NrSIMD-1:0]         valid, push;
    logic [NrSIMD-1:0][EW-1:0] head;
    logic                      pop, mis, mismatch_q;

    assign result_req_o = &valid;
    assign busy_o       = |valid;
    assign pop          = result_req_o && result_gnt_i;
    assign slice_gnt_o  = push;
    assign mismatch_o   = mismatch_q;
    assign result_id_o   = result_req_o ? head[0][EW-1 -: VidWidth] : '0;
    assign result_addr_o = result_req_o ? head[0][BW+ElenW +: VAddrWidth] : '0;

    for (genvar i = 0; i < NrSIMD; i++) begin : g_slice
        logic [EW-1:0] mem_q [Depth];
        logic [PW-1:0] wptr_q, rptr_q;
        logic [CW-1:0] cnt_q, cnt_d;
        assign valid[i] = cnt_q != '0;
        // A full FIFO refuses even when a pop frees a slot this cycle
        assign push[i]  = rst_ni && slice_req_i[i] && cnt_q != CW'(Depth) && !flush_i;
        assign cnt_d    = cnt_q + CW'(push[i]) - CW'(pop);
        assign head[i]  = mem_q[rptr_q];
        assign result_wdata_o[ElenW*i +: ElenW] = result_req_o ? head[i][BW +: ElenW] : '0;
        assign result_be_o[BW*i +: BW]          = result_req_o ? head[i][BW-1:0] : '0;
        always_ff @(posedge clk_i) begin
            if (push[i])
                mem_q[wptr_q] <= {slice_id_i[VidWidth*i +: VidWidth], slice_addr_i[VAddrWidth*i +: VAddrWidth],
                                  slice_wdata_i[ElenW*i +: ElenW], slice_be_i[BW*i +: BW]};
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else if (flush_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push[i]) wptr_q <= wptr_q + 1'b1;
                if (pop) rptr_q <= rptr_q + 1'b1;
                cnt_q <= cnt_d;
            end
        end
    end

    always_comb begin
        mis = 1'b0;
        for (int k = 1; k < NrSIMD; k++)
            mis = mis || (head[k][EW-1 -: IA] != head[0][EW-1 -: IA]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mismatch_q <= 1'b0;
        else if (flush_i) mismatch_q <= 1'b0;
        else if (result_req_o && mis) mismatch_q <= 1'b1;
    end
endmodule

// File: tb/tb_simd_result_merger.sv
// tb_simd_result_merger: directed vectors with hand-computed expectations for simd_result_merger
module tb_simd_result_merger;
    logic         clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
    logic [1:0]   slice_req_i = '0;
    logic [5:0]   slice_id_i = '0;
    logic [15:0]  slice_addr_i = '0;
    logic [127:0] slice_wdata_i = '0;
    logic [15:0]  slice_be_i = '0;
    logic [1:0]   slice_gnt_o;
    logic         result_req_o, result_gnt_i = 1'b0, mismatch_o, busy_o;
    logic [2:0]   result_id_o;
    logic [7:0]   result_addr_o;
    logic [127:0] result_wdata_o;
    logic [15:0]  result_be_o;
    int n_run = 0, n_fail = 0;

    simd_result_merger dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .slice_req_i(slice_req_i), .slice_id_i(slice_id_i), .slice_addr_i(slice_addr_i),
        .slice_wdata_i(slice_wdata_i), .slice_be_i(slice_be_i), .slice_gnt_o(slice_gnt_o),
        .result_req_o(result_req_o), .result_id_o(result_id_o), .result_addr_o(result_addr_o),
        .result_wdata_o(result_wdata_o), .result_be_o(result_be_o), .result_gnt_i(result_gnt_i),
        .mismatch_o(mismatch_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int s, input logic req, input logic [2:0] id, input logic [7:0] addr,
                         input logic [63:0] data, input logic [7:0] be);
        slice_req_i[s]          = req;
        slice_id_i[3*s +: 3]    = id;
        slice_addr_i[8*s +: 8]  = addr;
        slice_wdata_i[64*s +: 64] = data;
        slice_be_i[8*s +: 8]    = be;
    endtask

    initial begin
        #2;
        chk("rst_req", result_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_mis", mismatch_o, 0);
        chk("rst_wdata", result_wdata_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // 1: aligned slices
        result_gnt_i = 1'b1;
        drive(0, 1, 1, 8'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        drive(1, 1, 1, 8'h10, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF);
        #1 chk("t1_gnt", slice_gnt_o, 2'b11);
        chk("t1_req0", result_req_o, 0);
        step();
        slice_req_i = '0;
        #1 chk("t1_req1", result_req_o, 1);
        chk("t1_wdata", result_wdata_o, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        chk("t1_be", result_be_o, 16'hFFFF);
        chk("t1_id", result_id_o, 1);
        chk("t1_addr", result_addr_o, 8'h10);
        step();
        chk("t1_busy", busy_o, 0);
        chk("t1_req2", result_req_o, 0);

        // 2: skewed slices
        drive(0, 1, 2, 8'h30, 64'h1, 8'h0F);
        #1 chk("t2_gnt0", slice_gnt_o, 2'b01);
        step();
        slice_req_i = '0;
        #1 chk("t2_req_c1", result_req_o, 0);
        chk("t2_busy_c1", busy_o, 1);
        step();
        chk("t2_req_c2", result_req_o, 0);
        step();
        drive(1, 1, 2, 8'h30, 64'h2, 8'hF0);
        #1 chk("t2_gnt3", slice_gnt_o, 2'b10);
        chk("t2_req_c3", result_req_o, 0);
        step();
        slice_req_i = '0;
        #1 chk("t2_req_c4", result_req_o, 1);
        chk("t2_wdata", result_wdata_o, {64'h2, 64'h1});
        chk("t2_be", result_be_o, 16'hF00F);
        step();
        chk("t2_busy", busy_o, 0);

        // 3: backpressure and full FIFO
        result_gnt_i = 1'b0;
        drive(0, 1, 3, 8'h40, 64'h40, 8'h01);
        drive(1, 1, 3, 8'h40, 64'h140, 8'h01);
        #1 chk("t3_gnt_c0", slice_gnt_o, 2'b11);
        step();
        drive(0, 1, 3, 8'h41, 64'h41, 8'h01);
        drive(1, 1, 3, 8'h41, 64'h141, 8'h01);
        #1 chk("t3_gnt_c1", slice_gnt_o, 2'b11);
        step();
        drive(0, 1, 3, 8'h42, 64'h42, 8'h01);
        slice_req_i[1] = 1'b0;
        #1 chk("t3_gnt_c2", slice_gnt_o, 2'b00);
        step();
        chk("t3_gnt_c3", slice_gnt_o, 2'b00);
        chk("t3_addr_c3", result_addr_o, 8'h40);
        result_gnt_i = 1'b1;
        #1 chk("t3_gnt_c4", slice_gnt_o, 2'b00);
        chk("t3_wdata_c4", result_wdata_o, {64'h140, 64'h40});
        step();
        result_gnt_i = 1'b0;
        #1 chk("t3_gnt_c5", slice_gnt_o, 2'b01);
        chk("t3_addr_c5", result_addr_o, 8'h41);
        step();
        slice_req_i = '0;
        result_gnt_i = 1'b1;
        #1 chk("t3_req_c6", result_req_o, 1);
        chk("t3_wdata_c6", result_wdata_o, {64'h141, 64'h41});
        step();
        result_gnt_i = 1'b0;
        chk("t3_req_c7", result_req_o, 0);
        drive(1, 1, 3, 8'h42, 64'h142, 8'h01);
        step();
        slice_req_i = '0;
        chk("t3_addr_c8", result_addr_o, 8'h42);
        chk("t3_wdata_c8", result_wdata_o, {64'h142, 64'h42});
        chk("t3_mis", mismatch_o, 0);
        result_gnt_i = 1'b1;
        step();
        chk("t3_busy", busy_o, 0);

        // 4: id/addr mismatch is sticky until flush
        result_gnt_i = 1'b0;
        drive(0, 1, 4, 8'h20, 64'h5, 8'h01);
        drive(1, 1, 4, 8'h21, 64'h6, 8'h01);
        step();
        slice_req_i = '0;
        #1 chk("t4_req", result_req_o, 1);
        chk("t4_addr", result_addr_o, 8'h20);
        chk("t4_mis0", mismatch_o, 0);
        result_gnt_i = 1'b1;
        step();
        chk("t4_mis1", mismatch_o, 1);
        chk("t4_busy", busy_o, 0);
        drive(0, 1, 4, 8'h22, 64'h7, 8'h01);
        drive(1, 1, 4, 8'h22, 64'h8, 8'h01);
        step();
        slice_req_i = '0;
        #1 chk("t4_req2", result_req_o, 1);
        step();
        chk("t4_mis_sticky", mismatch_o, 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1 chk("t4_mis_clr", mismatch_o, 0);

        // 5: flush wins over a same-cycle grant
        result_gnt_i = 1'b0;
        drive(0, 1, 5, 8'h50, 64'h9, 8'h01);
        drive(1, 1, 5, 8'h50, 64'hA, 8'h01);
        step();
        slice_req_i = '0;
        flush_i = 1'b1;
        result_gnt_i = 1'b1;
        drive(0, 1, 5, 8'h51, 64'hB, 8'h01);
        #1 chk("t5_gnt_flush", slice_gnt_o, 2'b00);
        step();
        slice_req_i = '0;
        flush_i = 1'b0;
        result_gnt_i = 1'b0;
        #1 chk("t5_req", result_req_o, 0);
        chk("t5_busy", busy_o, 0);
        drive(0, 1, 5, 8'h55, 64'hC, 8'h01);
        drive(1, 1, 5, 8'h55, 64'hD, 8'h01);
        step();
        slice_req_i = '0;
        #1 chk("t5_req2", result_req_o, 1);
        chk("t5_addr2", result_addr_o, 8'h55);
        chk("t5_wdata2", result_wdata_o, {64'hD, 64'hC});
        result_gnt_i = 1'b1;
        step();
        chk("t5_busy2", busy_o, 0);

        // 6: asynchronous reset mid-operation
        result_gnt_i = 1'b0;
        drive(0, 1, 6, 8'h60, 64'hE, 8'h01);
        drive(1, 1, 6, 8'h60, 64'hF, 8'h01);
        step();
        drive(0, 1, 6, 8'h61, 64'h10, 8'h01);
        slice_req_i[1] = 1'b0;
        #1 chk("t6_gnt_pre", slice_gnt_o, 2'b01);
        chk("t6_req_pre", result_req_o, 1);
        #1 rst_ni = 1'b0;
        #1 chk("t6_req_rst", result_req_o, 0);
        chk("t6_busy_rst", busy_o, 0);
        chk("t6_gnt_rst", slice_gnt_o, 2'b00);
        chk("t6_wdata_rst", result_wdata_o, 0);
        #1 slice_req_i = '0;
        rst_ni = 1'b1;
        step();
        chk("t6_req_post", result_req_o, 0);
        chk("t6_busy_post", busy_o, 0);
        drive(0, 1, 7, 8'h70, 64'h11, 8'h01);
        drive(1, 1, 7, 8'h70, 64'h12, 8'h01);
        step();
        slice_req_i = '0;
        #1 chk("t6_addr_new", result_addr_o, 8'h70);
        chk("t6_wdata_new", result_wdata_o, {64'h12, 64'h11});
        result_gnt_i = 1'b1;
        step();
        chk("t6_busy_end", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
